// File: rtl/icache_direct.sv
// rtl/icache_direct.sv - direct-mapped read-only instruction cache with blocking single-word fill
// Optional hit/miss statistics counters enabled by defining ICACHE_STATS_EN.
module icache_direct #(
  parameter int SETS   = 16,
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  input  logic              flush,
  output logic              ihit,
  output logic [WORD_W-1:0] iload,
  output logic              mREN,
  output logic [WORD_W-1:0] maddr,
  input  logic              miwait,
  input  logic [WORD_W-1:0] mload
`ifdef ICACHE_STATS_EN
  , output logic [31:0]     hit_count
  , output logic [31:0]     miss_count
`endif
);

  localparam int IDXW = $clog2(SETS);
  localparam int TAGW = WORD_W - IDXW - 2;

  typedef enum logic {IDLE, MISS} state_t;

  state_t              state_q, state_d;
  logic [WORD_W-3:0]   miss_addr_q, miss_addr_d;
  logic [SETS-1:0]     valid_q, valid_d;
  logic [TAGW-1:0]     tag_q  [SETS];
  logic [WORD_W-1:0]   data_q [SETS];

  logic [IDXW-1:0]     idx;
  logic [TAGW-1:0]     tag_in;
  logic [IDXW-1:0]     fill_idx;
  logic [TAGW-1:0]     fill_tag;
  logic                lookup;
  logic                fill_en;
  logic                unused_byte_offset;

  assign idx                = iaddr[IDXW+1:2];
  assign tag_in             = iaddr[WORD_W-1:IDXW+2];
  assign fill_idx           = miss_addr_q[IDXW-1:0];
  assign fill_tag           = miss_addr_q[WORD_W-3:IDXW];
  assign maddr              = {miss_addr_q, 2'b00};
  assign unused_byte_offset = ^iaddr[1:0];

  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    valid_d     = valid_q;
    fill_en     = 1'b0;
    lookup      = 1'b0;
    ihit        = 1'b0;
    iload       = '0;
    mREN        = 1'b0;
    case (state_q)
      IDLE: begin
        lookup = iREN && valid_q[idx] && (tag_q[idx] == tag_in) && !flush;
        ihit   = lookup;
        iload  = lookup ? data_q[idx] : '0;
        if (iREN && !lookup && !flush) begin
          miss_addr_d = iaddr[WORD_W-1:2];
          state_d     = MISS;
        end
      end
      MISS: begin
        mREN = 1'b1;
        if (!miwait) begin
          fill_en = !flush;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Flush wins over everything: an in-flight fill is dropped, not written.
    if (flush) begin
      valid_d = '0;
      state_d = IDLE;
    end else if (fill_en) begin
      valid_d[fill_idx] = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      valid_q     <= valid_d;
    end
  end

  // Tag and data need no reset; the valid bits gate every use.
  always_ff @(posedge CLK) begin
    if (fill_en) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= mload;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (flush) begin
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
    end else begin
      if (ihit && hit_cnt_q != 32'hFFFF_FFFF)
        hit_cnt_d = hit_cnt_q + 32'd1;
      if (state_q == IDLE && state_d == MISS && miss_cnt_q != 32'hFFFF_FFFF)
        miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_direct.sv
// tb/tb_icache_direct.sv - directed self-checking bench for icache_direct
module tb_icache_direct;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        flush;
  logic        ihit;
  logic [31:0] iload;
  logic        mREN;
  logic [31:0] maddr;
  logic        miwait;
  logic [31:0] mload;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int n_vec = 0;
  int n_err = 0;

  icache_direct #(.SETS(16), .WORD_W(32)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .flush(flush),
    .ihit(ihit), .iload(iload), .mREN(mREN), .maddr(maddr),
    .miwait(miwait), .mload(mload)
`ifdef ICACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    nRST = 1'b0; iREN = 1'b1; iaddr = 32'h40; flush = 1'b0;
    miwait = 1'b0; mload = 32'h0;
    #2;
    n_vec++; if (ihit !== 1'b0) begin n_err++; $display("FAIL reset_ihit got=%0b exp=0", ihit); end
    n_vec++; if (mREN !== 1'b0) begin n_err++; $display("FAIL reset_mren got=%0b exp=0", mREN); end
    n_vec++; if (maddr !== 32'h0) begin n_err++; $display("FAIL reset_maddr got=%h exp=0", maddr); end
    n_vec++; if (iload !== 32'h0) begin n_err++; $display("FAIL reset_iload got=%h exp=0", iload); end
`ifdef ICACHE_STATS_EN
    n_vec++; if (hit_count !== 32'h0 || miss_count !== 32'h0) begin
      n_err++; $display("FAIL reset_stats got=%0d/%0d exp=0/0", hit_count, miss_count); end
`endif
    tick();
    iREN = 1'b0;
    nRST = 1'b1;
  endtask

  task automatic test_cold_fetch();
    iREN = 1'b1; iaddr = 32'h40; mload = 32'h2001_0005; miwait = 1'b1;
    #1;
    n_vec++; if (ihit !== 1'b0 || mREN !== 1'b0) begin
      n_err++; $display("FAIL cold_req ihit=%0b mREN=%0b exp=0/0", ihit, mREN); end
    tick();
    for (int i = 0; i < 4; i++) begin
      miwait = (i < 3);
      #1;
      n_vec++; if (mREN !== 1'b1 || maddr !== 32'h40 || ihit !== 1'b0) begin
        n_err++; $display("FAIL cold_miss%0d mREN=%0b maddr=%h ihit=%0b exp=1/40/0", i, mREN, maddr, ihit); end
      tick();
    end
    #1;
    n_vec++; if (ihit !== 1'b1 || iload !== 32'h2001_0005 || mREN !== 1'b0) begin
      n_err++; $display("FAIL cold_hit ihit=%0b iload=%h mREN=%0b exp=1/20010005/0", ihit, iload, mREN); end
    tick();
    iREN = 1'b0;
    #1;
`ifdef ICACHE_STATS_EN
    n_vec++; if (hit_count !== 32'd1 || miss_count !== 32'd1) begin
      n_err++; $display("FAIL cold_stats got=%0d/%0d exp=1/1", hit_count, miss_count); end
`endif
    n_vec++; if (ihit !== 1'b0 || iload !== 32'h0) begin
      n_err++; $display("FAIL idle_noreq ihit=%0b iload=%h exp=0/0", ihit, iload); end
    tick();
  endtask

  task automatic test_byte_offset();
    iREN = 1'b1; iaddr = 32'h43;
    #1;
    n_vec++; if (ihit !== 1'b1 || iload !== 32'h2001_0005 || mREN !== 1'b0) begin
      n_err++; $display("FAIL offset_hit ihit=%0b iload=%h mREN=%0b exp=1/20010005/0", ihit, iload, mREN); end
    tick();
    iREN = 1'b0;
  endtask

  task automatic test_conflict();
    iREN = 1'b1; iaddr = 32'h80; mload = 32'h1111_2222; miwait = 1'b0;
    #1;
    n_vec++; if (ihit !== 1'b0) begin n_err++; $display("FAIL conflict_miss80 ihit=%0b exp=0", ihit); end
    tick(); #1;
    n_vec++; if (mREN !== 1'b1 || maddr !== 32'h80) begin
      n_err++; $display("FAIL conflict_fill80 mREN=%0b maddr=%h exp=1/80", mREN, maddr); end
    tick(); #1;
    n_vec++; if (ihit !== 1'b1 || iload !== 32'h1111_2222) begin
      n_err++; $display("FAIL conflict_hit80 ihit=%0b iload=%h exp=1/11112222", ihit, iload); end
    tick();
    iaddr = 32'h40; mload = 32'h2001_0005;
    #1;
    n_vec++; if (ihit !== 1'b0) begin n_err++; $display("FAIL conflict_miss40 ihit=%0b exp=0", ihit); end
    tick(); #1;
    n_vec++; if (mREN !== 1'b1 || maddr !== 32'h40) begin
      n_err++; $display("FAIL conflict_fill40 mREN=%0b maddr=%h exp=1/40", mREN, maddr); end
    tick(); #1;
    n_vec++; if (ihit !== 1'b1 || iload !== 32'h2001_0005) begin
      n_err++; $display("FAIL conflict_hit40 ihit=%0b iload=%h exp=1/20010005", ihit, iload); end
    tick();
    iREN = 1'b0;
  endtask

  task automatic test_iren_drop();
    iREN = 1'b1; iaddr = 32'h48; mload = 32'hAAAA_5555; miwait = 1'b1;
    #1;
    n_vec++; if (ihit !== 1'b0) begin n_err++; $display("FAIL drop_miss ihit=%0b exp=0", ihit); end
    tick();
    iREN = 1'b0; iaddr = 32'h0; miwait = 1'b0;
    #1;
    n_vec++; if (mREN !== 1'b1 || maddr !== 32'h48) begin
      n_err++; $display("FAIL drop_latched mREN=%0b maddr=%h exp=1/48", mREN, maddr); end
    tick(); #1;
    n_vec++; if (mREN !== 1'b0) begin n_err++; $display("FAIL drop_idle mREN=%0b exp=0", mREN); end
    tick();
    iREN = 1'b1; iaddr = 32'h48;
    #1;
    n_vec++; if (ihit !== 1'b1 || iload !== 32'hAAAA_5555) begin
      n_err++; $display("FAIL drop_refetch ihit=%0b iload=%h exp=1/aaaa5555", ihit, iload); end
    tick();
    iREN = 1'b0;
  endtask

  task automatic test_flush_miss();
    iREN = 1'b1; iaddr = 32'h104; mload = 32'hDEAD_BEEF; miwait = 1'b0;
    #1;
    n_vec++; if (ihit !== 1'b0) begin n_err++; $display("FAIL fmiss_req ihit=%0b exp=0", ihit); end
    tick();
    flush = 1'b1;
    #1;
    n_vec++; if (mREN !== 1'b1 || maddr !== 32'h104) begin
      n_err++; $display("FAIL fmiss_mren mREN=%0b maddr=%h exp=1/104", mREN, maddr); end
    tick();
    flush = 1'b0;
    #1;
    n_vec++; if (ihit !== 1'b0 || mREN !== 1'b0) begin
      n_err++; $display("FAIL fmiss_nowrite ihit=%0b mREN=%0b exp=0/0", ihit, mREN); end
`ifdef ICACHE_STATS_EN
    n_vec++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
      n_err++; $display("FAIL fmiss_stats got=%0d/%0d exp=0/0", hit_count, miss_count); end
`endif
    tick(); #1;
    n_vec++; if (mREN !== 1'b1) begin n_err++; $display("FAIL fmiss_remiss mREN=%0b exp=1", mREN); end
    tick(); #1;
    n_vec++; if (ihit !== 1'b1 || iload !== 32'hDEAD_BEEF) begin
      n_err++; $display("FAIL fmiss_hit ihit=%0b iload=%h exp=1/deadbeef", ihit, iload); end
    tick();
    iaddr = 32'h48;
    #1;
    n_vec++; if (ihit !== 1'b0) begin n_err++; $display("FAIL fmiss_48gone ihit=%0b exp=0", ihit); end
    iREN = 1'b0;
    tick();
  endtask

  task automatic test_flush_idle();
    iREN = 1'b1; iaddr = 32'h104; flush = 1'b1;
    #1;
    n_vec++; if (ihit !== 1'b0 || iload !== 32'h0) begin
      n_err++; $display("FAIL fidle_forced ihit=%0b iload=%h exp=0/0", ihit, iload); end
    tick();
    flush = 1'b0;
    #1;
    n_vec++; if (ihit !== 1'b0) begin n_err++; $display("FAIL fidle_invalid ihit=%0b exp=0", ihit); end
    tick(); #1;
    n_vec++; if (mREN !== 1'b1) begin n_err++; $display("FAIL fidle_refill mREN=%0b exp=1", mREN); end
    tick();
    iREN = 1'b0;
  endtask

  task automatic test_reset_mid_miss();
    iREN = 1'b1; iaddr = 32'h40; mload = 32'h2001_0005; miwait = 1'b1;
    tick(); #1;
    n_vec++; if (mREN !== 1'b1) begin n_err++; $display("FAIL rst_pre mREN=%0b exp=1", mREN); end
    nRST = 1'b0;
    #1;
    n_vec++; if (mREN !== 1'b0 || maddr !== 32'h0) begin
      n_err++; $display("FAIL rst_async mREN=%0b maddr=%h exp=0/0", mREN, maddr); end
    tick();
    nRST = 1'b1; miwait = 1'b0; iaddr = 32'h104;
    #1;
    n_vec++; if (ihit !== 1'b0 || mREN !== 1'b0) begin
      n_err++; $display("FAIL rst_invalid104 ihit=%0b mREN=%0b exp=0/0", ihit, mREN); end
    tick(); #1;
    n_vec++; if (mREN !== 1'b1 || maddr !== 32'h104) begin
      n_err++; $display("FAIL rst_remiss mREN=%0b maddr=%h exp=1/104", mREN, maddr); end
    tick();
    iaddr = 32'h40;
    #1;
    n_vec++; if (ihit !== 1'b0) begin n_err++; $display("FAIL rst_invalid40 ihit=%0b exp=0", ihit); end
    iREN = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_cold_fetch();
    test_byte_offset();
    test_conflict();
    test_iren_drop();
    test_flush_miss();
    test_flush_idle();
    test_reset_mid_miss();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
